// File: rtl/cve2_wb_buffer_if.sv
// Writeback buffer bus: ID-side offer, LSU response, register-file write,
// retirement, hazard lookup and occupancy signals.
interface cve2_wb_buffer_if #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic             en_wb_i;
  logic             ready_wb_o;
  logic [1:0]       instr_type_wb_i;
  logic [Width-1:0] pc_id_i;
  logic             instr_is_compressed_id_i;
  logic             instr_perf_count_id_i;
  logic [4:0]       rf_waddr_id_i;
  logic [Width-1:0] rf_wdata_id_i;
  logic             rf_we_id_i;
  logic             lsu_resp_valid_i;
  logic             lsu_resp_err_i;
  logic [Width-1:0] rf_wdata_lsu_i;
  logic             rf_we_lsu_i;
  logic             flush_i;
  logic [4:0]       rf_raddr_a_i;
  logic [4:0]       rf_raddr_b_i;
  logic             hazard_a_o;
  logic             hazard_b_o;
  logic [4:0]       rf_waddr_wb_o;
  logic [Width-1:0] rf_wdata_wb_o;
  logic             rf_we_wb_o;
  logic [Width-1:0] pc_wb_o;
  logic             instr_done_wb_o;
  logic             perf_instr_ret_wb_o;
  logic             perf_instr_ret_compressed_wb_o;
  logic             outstanding_load_wb_o;
  logic             outstanding_store_wb_o;
  logic [CntW-1:0]  count_o;

  modport slave (
    input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
           instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
           lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i, rf_we_lsu_i,
           flush_i, rf_raddr_a_i, rf_raddr_b_i,
    output ready_wb_o, hazard_a_o, hazard_b_o, rf_waddr_wb_o, rf_wdata_wb_o,
           rf_we_wb_o, pc_wb_o, instr_done_wb_o, perf_instr_ret_wb_o,
           perf_instr_ret_compressed_wb_o, outstanding_load_wb_o,
           outstanding_store_wb_o, count_o
  );

  modport master (
    output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
           instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
           lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i, rf_we_lsu_i,
           flush_i, rf_raddr_a_i, rf_raddr_b_i,
    input  ready_wb_o, hazard_a_o, hazard_b_o, rf_waddr_wb_o, rf_wdata_wb_o,
           rf_we_wb_o, pc_wb_o, instr_done_wb_o, perf_instr_ret_wb_o,
           perf_instr_ret_compressed_wb_o, outstanding_load_wb_o,
           outstanding_store_wb_o, count_o
  );
endinterface

// File: rtl/cve2_wb_buffer.sv
// In-order writeback buffer: a circular FIFO of in-flight instructions that
// retire from the head once they are non-LSU or their LSU response arrives.
module cve2_wb_buffer #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cve2_wb_buffer_if.slave    wb
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(Depth - 1);

  // Explicit wrap so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  logic             valid_q [Depth];
  logic [1:0]       type_q  [Depth];
  logic [Width-1:0] pc_q    [Depth];
  logic             cmp_q   [Depth];
  logic             cnt_q   [Depth];
  logic [4:0]       waddr_q [Depth];
  logic [Width-1:0] wdata_q [Depth];
  logic             we_q    [Depth];

  ptr_t            head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic head_valid, head_load, head_other, head_done;
  logic accept, ready;
  logic             we_out;
  logic [Width-1:0] wdata_sel;

  // Head decode, handshake and retirement outputs.
  always_comb begin
    head_valid = valid_q[head_q];
    head_load  = (type_q[head_q] == 2'd0);
    head_other = type_q[head_q][1];  // 2 and 3 are both "other"
    head_done  = head_valid & (head_other | wb.lsu_resp_valid_i);
    ready      = (count_q < CntW'(Depth)) | head_done;
    accept     = wb.en_wb_i & ready & ~wb.flush_i;

    we_out    = 1'b0;
    wdata_sel = '0;
    if (head_done) begin
      if (head_load) begin
        we_out    = wb.rf_we_lsu_i & ~wb.lsu_resp_err_i;
        wdata_sel = wb.rf_wdata_lsu_i;
      end else if (head_other) begin
        we_out    = we_q[head_q];
        wdata_sel = wdata_q[head_q];
      end
    end

    wb.ready_wb_o      = ready;
    wb.instr_done_wb_o = head_done;
    wb.rf_we_wb_o      = we_out;
    wb.rf_wdata_wb_o   = we_out ? wdata_sel : '0;
    wb.rf_waddr_wb_o   = head_valid ? waddr_q[head_q] : 5'd0;
    wb.pc_wb_o         = head_valid ? pc_q[head_q] : '0;
    wb.perf_instr_ret_wb_o = head_done & cnt_q[head_q] &
                             ~(wb.lsu_resp_valid_i & wb.lsu_resp_err_i);
    wb.perf_instr_ret_compressed_wb_o = wb.perf_instr_ret_wb_o & cmp_q[head_q];
    wb.count_o = count_q;
  end

  // Pending-write hazard lookup and outstanding LSU flags over all valid entries.
  always_comb begin
    wb.hazard_a_o             = 1'b0;
    wb.hazard_b_o             = 1'b0;
    wb.outstanding_load_wb_o  = 1'b0;
    wb.outstanding_store_wb_o = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (valid_q[i]) begin
        if ((we_q[i] | (type_q[i] == 2'd0)) && (waddr_q[i] == wb.rf_raddr_a_i)) begin
          wb.hazard_a_o = 1'b1;
        end
        if ((we_q[i] | (type_q[i] == 2'd0)) && (waddr_q[i] == wb.rf_raddr_b_i)) begin
          wb.hazard_b_o = 1'b1;
        end
        if (type_q[i] == 2'd0) wb.outstanding_load_wb_o  = 1'b1;
        if (type_q[i] == 2'd1) wb.outstanding_store_wb_o = 1'b1;
      end
    end
    if (wb.rf_raddr_a_i == 5'd0) wb.hazard_a_o = 1'b0;
    if (wb.rf_raddr_b_i == 5'd0) wb.hazard_b_o = 1'b0;
  end

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wb.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (head_done) head_d = ptr_inc(head_q);
      if (accept)    tail_d = ptr_inc(tail_q);
      count_d = count_q + CntW'(accept) - CntW'(head_done);
    end
  end

  // Entry storage; an accept into the slot just retired (full buffer) wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        valid_q[i] <= 1'b0;
        type_q[i]  <= 2'd0;
        pc_q[i]    <= '0;
        cmp_q[i]   <= 1'b0;
        cnt_q[i]   <= 1'b0;
        waddr_q[i] <= 5'd0;
        wdata_q[i] <= '0;
        we_q[i]    <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (wb.flush_i) begin
        for (int i = 0; i < int'(Depth); i++) valid_q[i] <= 1'b0;
      end else begin
        if (head_done) valid_q[head_q] <= 1'b0;
        if (accept) begin
          valid_q[tail_q] <= 1'b1;
          type_q[tail_q]  <= wb.instr_type_wb_i;
          pc_q[tail_q]    <= wb.pc_id_i;
          cmp_q[tail_q]   <= wb.instr_is_compressed_id_i;
          cnt_q[tail_q]   <= wb.instr_perf_count_id_i;
          waddr_q[tail_q] <= wb.rf_waddr_id_i;
          wdata_q[tail_q] <= wb.rf_wdata_id_i;
          we_q[tail_q]    <= wb.rf_we_id_i;
        end
      end
    end
  end

endmodule
